// File: rtl/mem_resp_pkg.sv
// mem_resp shared types: state encoding, widths and address check.
// Imported by the interface, the RAM and the responder FSM.
package mem_resp_pkg;

  localparam int REG_LEN    = 32;
  localparam int MEMR_LAT_W = 3;

  typedef enum logic [1:0] {
    MEMR_IDLE = 2'd0,
    MEMR_WAIT = 2'd1,
    MEMR_RESP = 2'd2
  } memr_state_e;

  // Misaligned word access or any address bit above the array.
  function automatic logic addr_bad(
    input logic [REG_LEN-1:0] a,
    input int                 aw
  );
    addr_bad = (a[1:0] != 2'b00) ||
               ((a >> (aw + 2)) != '0);
  endfunction

endpackage

// File: rtl/mem_resp_if.sv
// Core-to-memory request/response bundle.
// master = core side, slave = mem_resp.
interface mem_resp_if;
  import mem_resp_pkg::*;

  logic               req;
  logic               we;
  logic [REG_LEN-1:0] addr;
  logic [REG_LEN-1:0] wdata;
  logic [3:0]         be;
  logic [REG_LEN-1:0] rdata;
  logic               ready;
  logic               err;

  modport master (
    output req, we, addr, wdata, be,
    input  rdata, ready, err
  );

  modport slave (
    input  req, we, addr, wdata, be,
    output rdata, ready, err
  );

endinterface

// File: rtl/mem_array.sv
// Single-port word RAM, byte-enable write, registered read.
// No reset: contents survive rst.
module mem_array
  import mem_resp_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic               clk,
  input  logic               i_we,
  input  logic [3:0]         i_be,
  input  logic [ADDR_W-1:0]  i_addr,
  input  logic [REG_LEN-1:0] i_wdata,
  input  logic               i_re,
  output logic [REG_LEN-1:0] o_rdata
);

  logic [REG_LEN-1:0] r_mem [2**ADDR_W];
  logic [REG_LEN-1:0] r_q;

  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int i = 0; i < 4; i++) begin
        if (i_be[i]) begin
          r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
        end
      end
    end
    if (i_re) begin
      r_q <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_q;

endmodule

// File: rtl/mem_resp.sv
// Memory responder: accepts one request, waits LATENCY cycles,
// then pulses ready with read data or err for one cycle.
module mem_resp
  import mem_resp_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 1
) (
  input logic       clk,
  input logic       rst,
  mem_resp_if.slave bus
);

  localparam logic [MEMR_LAT_W-1:0] LAT =
    MEMR_LAT_W'(LATENCY);

  memr_state_e r_state;
  memr_state_e w_next;

  logic [MEMR_LAT_W-1:0] r_cnt;
  logic [MEMR_LAT_W-1:0] w_cnt_nxt;

  logic [ADDR_W-1:0]  r_idx;
  logic               r_we;
  logic [REG_LEN-1:0] r_wdata;
  logic [3:0]         r_be;
  logic               r_err;
  logic               r_zero;

  logic               w_idle;
  logic               w_accept;
  logic               w_enter;
  logic               w_re;
  logic               w_wr;
  logic [ADDR_W-1:0]  w_acc_idx;
  logic               w_acc_we;
  logic               w_acc_err;
  logic               w_in_err;
  logic [REG_LEN-1:0] w_q;

  assign w_idle   = (r_state == MEMR_IDLE);
  assign w_accept = w_idle && bus.req;
  assign w_in_err = addr_bad(bus.addr, ADDR_W);

  // Live inputs when accepting, captured copy afterwards;
  // a zero-latency accept reads the array on its own edge.
  assign w_acc_idx = w_idle ? bus.addr[ADDR_W+1:2] : r_idx;
  assign w_acc_we  = w_idle ? bus.we : r_we;
  assign w_acc_err = w_idle ? w_in_err : r_err;

  assign w_enter = (w_next == MEMR_RESP) &&
                   (r_state != MEMR_RESP) && !rst;
  assign w_re    = w_enter && !w_acc_we && !w_acc_err;
  assign w_wr    = (r_state == MEMR_RESP) && !rst &&
                   r_we && !r_err;

  always_comb begin
    w_next    = r_state;
    w_cnt_nxt = r_cnt;
    unique case (r_state)
      MEMR_IDLE: begin
        if (bus.req) begin
          w_cnt_nxt = LAT;
          w_next    = (LAT != '0) ? MEMR_WAIT : MEMR_RESP;
        end
      end
      MEMR_WAIT: begin
        if (r_cnt <= 1) begin
          w_cnt_nxt = '0;
          w_next    = MEMR_RESP;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      MEMR_RESP: w_next = MEMR_IDLE;
      default:   w_next = MEMR_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= MEMR_IDLE;
      r_cnt   <= '0;
      r_zero  <= 1'b1;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_nxt;
      if (w_enter) begin
        if (w_acc_err) begin
          r_zero <= 1'b1;
        end else if (!w_acc_we) begin
          r_zero <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_idx   <= bus.addr[ADDR_W+1:2];
      r_we    <= bus.we;
      r_wdata <= bus.wdata;
      r_be    <= bus.be;
      r_err   <= w_in_err;
    end
  end

  mem_array #(
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk     (clk),
    .i_we    (w_wr),
    .i_be    (r_be),
    .i_addr  (w_acc_idx),
    .i_wdata (r_wdata),
    .i_re    (w_re),
    .o_rdata (w_q)
  );

  assign bus.ready = (r_state == MEMR_RESP) && !rst;
  assign bus.err   = bus.ready && r_err;
  assign bus.rdata = r_zero ? '0 : w_q;

endmodule

// File: tb/tb_mem_resp.sv
// Scoreboard bench for mem_resp at LATENCY 0/1/3/7.
// Reference model: word memory map plus per-DUT last read value.
module tb_mem_resp;
  import mem_resp_pkg::*;

  localparam int ND = 4;

  function automatic int lat_of(input int d);
    return (d == 0) ? 0 : (d == 1) ? 1 : (d == 2) ? 3 : 7;
  endfunction

  logic clk = 1'b0;
  int   cyc = 0;

  logic [ND-1:0]       rst_v = '1;
  logic [ND-1:0]       req_v = '0;
  logic [ND-1:0]       we_v  = '0;
  logic [ND-1:0][3:0]  be_v  = '0;
  logic [ND-1:0][31:0] addr_v  = '0;
  logic [ND-1:0][31:0] wdata_v = '0;
  wire  [ND-1:0]       rdy_v;
  wire  [ND-1:0]       err_v;
  wire  [ND-1:0][31:0] rdata_v;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar i = 0; i < ND; i++) begin : g
    mem_resp_if ifc();
    assign ifc.req   = req_v[i];
    assign ifc.we    = we_v[i];
    assign ifc.addr  = addr_v[i];
    assign ifc.wdata = wdata_v[i];
    assign ifc.be    = be_v[i];
    assign rdy_v[i]   = ifc.ready;
    assign err_v[i]   = ifc.err;
    assign rdata_v[i] = ifc.rdata;
    mem_resp #(
      .ADDR_W  (10),
      .LATENCY (lat_of(i))
    ) dut (
      .clk (clk),
      .rst (rst_v[i]),
      .bus (ifc.slave)
    );
  end

  typedef struct {
    int          d;
    int          t;
    logic        err;
    logic [31:0] rd;
  } exp_t;

  exp_t        sbq[$];
  exp_t        me;
  logic [31:0] ref_mem [int];
  logic [31:0] last_rd [ND];
  int          n_pass  = 0;
  int          n_total = 0;
  bit          mon_en  = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h (cyc %0d)",
                  nm, act, exp, cyc);
  endtask

  function automatic bit bad(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a[31:12] != '0);
  endfunction

  function automatic int key_of(input int d,
                                input logic [31:0] a);
    return d * 4096 + int'(a[11:2]);
  endfunction

  // Apply the spec rules to the model and queue the response.
  task automatic model_push(input int d, input bit w,
                            input logic [31:0] a,
                            input logic [31:0] wd,
                            input logic [3:0] b);
    exp_t        e;
    logic [31:0] cur;
    int          k;
    k = key_of(d, a);
    if (bad(a)) begin
      last_rd[d] = '0;
    end else if (w) begin
      cur = ref_mem.exists(k) ? ref_mem[k] : '0;
      for (int i = 0; i < 4; i++)
        if (b[i]) cur[8*i +: 8] = wd[8*i +: 8];
      ref_mem[k] = cur;
    end else begin
      last_rd[d] = ref_mem.exists(k) ? ref_mem[k] : 'x;
    end
    e.d   = d;
    e.t   = cyc + lat_of(d);
    e.err = bad(a);
    e.rd  = last_rd[d];
    sbq.push_back(e);
  endtask

  task automatic drive(input int d, input bit w,
                       input logic [31:0] a,
                       input logic [31:0] wd,
                       input logic [3:0] b);
    req_v[d]   = 1'b1;
    we_v[d]    = w;
    addr_v[d]  = a;
    wdata_v[d] = wd;
    be_v[d]    = b;
  endtask

  task automatic issue(input int d, input bit w,
                       input logic [31:0] a,
                       input logic [31:0] wd,
                       input logic [3:0] b);
    drive(d, w, a, wd, b);
    @(posedge clk); #1;
    req_v[d] = 1'b0;
    model_push(d, w, a, wd, b);
    repeat (lat_of(d) + 1) @(posedge clk);
    #1;
  endtask

  // req held high: one accept every LATENCY+2 edges.
  task automatic hold(input int d, input int n,
                      input logic [31:0] a);
    drive(d, 1'b0, a, '0, 4'h0);
    @(posedge clk); #1;
    model_push(d, 1'b0, a, '0, 4'h0);
    for (int k = 1; k < n; k++) begin
      repeat (lat_of(d) + 2) @(posedge clk);
      #1;
      model_push(d, 1'b0, a, '0, 4'h0);
    end
    req_v[d] = 1'b0;
    repeat (lat_of(d) + 1) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      for (int d = 0; d < ND; d++) begin
        if (rdy_v[d] === 1'b1) begin
          if (sbq.size() == 0 || sbq[0].d != d) begin
            n_total++;
            $display("FAIL unexpected_ready: dut%0d cyc %0d",
                     d, cyc);
          end else begin
            me = sbq.pop_front();
            chk("ready_cycle", cyc, me.t);
            chk("err", {31'b0, err_v[d]}, {31'b0, me.err});
            chk("rdata", rdata_v[d], me.rd);
          end
        end else begin
          chk("idle_ready_err", {30'b0, rdy_v[d], err_v[d]}, '0);
        end
      end
    end
  end

  initial begin
    logic [31:0] a;
    int          r;
    for (int d = 0; d < ND; d++) last_rd[d] = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_v = '0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      for (int d = 0; d < ND; d++) begin
        chk("reset_ready", {31'b0, rdy_v[d]}, '0);
        chk("reset_err", {31'b0, err_v[d]}, '0);
        chk("reset_rdata", rdata_v[d], '0);
      end
    end
    @(posedge clk); #1;
    mon_en = 1;

    issue(1, 1, 32'h10, 32'hDEADBEEF, 4'hF);
    issue(1, 0, 32'h10, '0, 4'h0);
    issue(1, 1, 32'h10, 32'h11223344, 4'b0101);
    issue(1, 0, 32'h10, '0, 4'h0);
    chk("byte_merge_model", ref_mem[key_of(1, 32'h10)],
        32'hDE22BE44);
    issue(1, 0, 32'h12, '0, 4'h0);
    issue(1, 1, 32'h0, 32'hA5A55A5A, 4'hF);
    issue(1, 1, 32'h1000, 32'hFFFFFFFF, 4'hF);
    issue(1, 0, 32'h0, '0, 4'h0);
    issue(1, 1, 32'h14, 32'h01020304, 4'h0);
    issue(1, 0, 32'h14, '0, 4'h0);

    issue(0, 1, 32'h0, 32'h0BADF00D, 4'hF);
    hold(0, 6, 32'h0);
    issue(3, 1, 32'h0, 32'h76543210, 4'hF);
    hold(3, 4, 32'h0);

    issue(2, 1, 32'h20, 32'h12345678, 4'hF);
    drive(2, 1, 32'h20, 32'hCAFEF00D, 4'hF);
    @(posedge clk); #1;
    req_v[2] = 1'b0;
    @(posedge clk); #1;
    rst_v[2] = 1'b1;
    @(posedge clk); #1;
    rst_v[2] = 1'b0;
    last_rd[2] = '0;
    chk("rst_wait_rdata", rdata_v[2], '0);
    repeat (6) @(posedge clk);
    #1;
    drive(2, 1, 32'h20, 32'hCAFEF00D, 4'hF);
    @(posedge clk); #1;
    req_v[2] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_v[2] = 1'b1;
    @(posedge clk); #1;
    rst_v[2] = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    issue(2, 0, 32'h20, '0, 4'h0);

    for (int d = 0; d < ND; d++) begin
      for (int w = 0; w < 8; w++)
        issue(d, 1, 32'(w) << 2, $urandom, 4'hF);
      for (int n = 0; n < 25; n++) begin
        a = 32'($urandom_range(0, 7)) << 2;
        r = $urandom_range(0, 7);
        if (r == 0) a = a | 32'($urandom_range(1, 3));
        else if (r == 1)
          a = a | (32'h1 << $urandom_range(12, 31));
        issue(d, 1'($urandom_range(0, 1)), a, $urandom,
              4'($urandom_range(0, 15)));
      end
    end

    repeat (12) @(posedge clk);
    #1;
    chk("scoreboard_drained", sbq.size(), '0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mem_resp.md
# mem_resp

Memory responder for the rysy core: the slave end of the core's memory address path. It accepts a single request (address, write flag, write data, byte enables), holds it for a configurable number of wait states, performs the word access on an internal RAM array and returns a one-cycle `ready` pulse with read data or an error flag. It sits between the core's address/data outputs and main memory, and serves both instruction fetch and load/store.

## Interface
Parameters:
- `ADDR_W`, default 10: log2 of memory depth in 32-bit words (1024 words = 4 KiB).
- `LATENCY`, default 1: wait states inserted before the response; legal range 0..7.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `req`  in  1  request strobe; sampled only in IDLE.
- `we`  in  1  1 = write, 0 = read.
- `addr`  in  `REG_LEN`  byte address.
- `wdata`  in  `REG_LEN`  write data.
- `be`  in  4  byte enables; `be[i]` covers `wdata[8i+7:8i]`.
- `rdata`  out  `REG_LEN`  read data; valid when `ready`=1 and `we` was 0.
- `ready`  out  1  one-cycle response pulse.
- `err`  out  1  qualifies `ready`; 1 = request rejected.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - `req`=1 at a clock edge captures `addr`, `we`, `wdata` and `be` into internal registers.
  - Wait counter loads `LATENCY`.
  - Next state is WAIT if `LATENCY`>0, otherwise RESP.
  - `req`=0 keeps the FSM in IDLE.
- WAIT:
  - Counter decrements each cycle; the FSM moves to RESP when the counter reaches 1.
  - `req` and the other inputs are ignored; the captured values are used.
- RESP:
  - `ready`=1 for exactly this cycle.
  - Next state is IDLE unconditionally. A `req` held high is re-sampled in IDLE one cycle later, so there are no back-to-back accepts.
- Error check uses the captured address:
  - misaligned: `addr[1:0]`≠0;
  - out of range: `addr[REG_LEN-1:ADDR_W+2]`≠0.
  - On error: `err`=1 with `ready`, no array write, `rdata` forced to 0.
- Write: on the clock edge ending RESP, bytes with `be[i]`=1 are written to word `addr[ADDR_W+1:2]`. `be`=0 completes normally with no change.
- Read: `rdata` is registered from the array on entry to RESP and holds its value until the next read response. Write responses leave `rdata` unchanged.
- A read that follows a write to the same word returns the written data. This holds automatically because the write lands before the next accept.

## Timing
- Reset values: state IDLE, `ready`=0, `err`=0, `rdata`=0, counter 0.
- Array contents are not cleared by reset.
- Latency: with `req` sampled at edge k, `ready` is high in the cycle between edges k+LATENCY and k+LATENCY+1.
  - `LATENCY`=0 gives `ready` in the cycle after the accepting edge.
  - Throughput is one request per LATENCY+2 cycles.
- `err` is valid only while `ready`=1 and is 0 otherwise.
- `rst` in WAIT or RESP:
  - the transaction is abandoned and no write occurs, even if asserted during the RESP cycle;
  - `ready` stays 0;
  - the next cycle is IDLE.
- `rst` has priority over `req` in the same cycle.

## Structure
- `mem_resp.vh`: state encodings `MEMR_IDLE`, `MEMR_WAIT`, `MEMR_RESP` (2-bit), and `MEMR_LAT_W`=3.
- `rysy_pkg.vh`: `REG_LEN` is taken from here.
- Sub-module `mem_array`: a single-port word RAM of depth 2^ADDR_W. It has a synchronous per-byte-enable write and a synchronous read. It holds no FSM logic and has no reset.
- `mem_resp`: owns the FSM, wait counter, capture registers, error decode and `rdata` register.

## Test plan
- Reset, then idle: `ready`=0, `err`=0, `rdata`=0 for 10 cycles with `req`=0.
- `LATENCY`=1: write 0xDEADBEEF to 0x10 with `be`=4'hF, then read 0x10. `ready` follows each accept by 2 cycles; the read returns 0xDEADBEEF with `err`=0.
- Byte enables: write 0x11223344 with `be`=4'b0101 over existing 0xDEADBEEF → the read returns 0xDE22BE44.
- Errors:
  - read 0x12 → `ready`=1, `err`=1, `rdata`=0;
  - write to 0x1000 with `ADDR_W`=10 → `err`=1, and a following read of 0x0 shows unchanged contents.
- `LATENCY`=0 and `LATENCY`=7 with `req` held high: `ready` pulses every 2 and every 9 cycles respectively, each pulse exactly one cycle wide.
- Write 0xCAFEF00D to 0x20 with `LATENCY`=3 and assert `rst` during WAIT → no `ready`, and a later read of 0x20 returns the old value.
